// File: rtl/header_tuple_extractor_if.sv
// Bundles the 256-bit header stream and the 72-bit lookup-key handshake of the tuple extractor.
// slave is the extractor's side; master is the packet source / match-engine side.
interface header_tuple_extractor_if #(
  parameter int DATA_WIDTH = 256
);
  logic [DATA_WIDTH-1:0]   s_axis_tdata;
  logic [DATA_WIDTH/8-1:0] s_axis_tkeep;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic                    s_axis_tlast;
  logic [71:0]             m_key;
  logic                    m_key_valid;
  logic                    m_key_ready;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_key, m_key_valid,
    input  m_key_ready
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_key, m_key_valid,
    output m_key_ready
  );
endinterface

// File: rtl/header_tuple_extractor.sv
// Extracts {protocol, src_ip, dst_ip} from the first two beats of IPv4/Ethernet frames and keeps stats.
// Key valid 1 cycle after beat 1 is accepted; tready drops only in HDR1 while an unaccepted key is held.
module header_tuple_extractor #(
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int C_CNT_WIDTH         = 32
) (
  input  logic                   axi_aclk,
  input  logic                   axi_resetn,
  header_tuple_extractor_if.slave bus,
  output logic [C_CNT_WIDTH-1:0] pkt_cnt,
  output logic [C_CNT_WIDTH-1:0] non_ip_cnt,
  output logic [C_CNT_WIDTH-1:0] runt_cnt
);
  typedef struct packed {
    logic [7:0]  protocol;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } key_t;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HDR1  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [7:0] byte_at(input logic [C_S_AXIS_DATA_WIDTH-1:0] d, input int i);
    return d[C_S_AXIS_DATA_WIDTH-1-8*i -: 8];
  endfunction

  function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] c, input logic inc);
    return (inc && (c != '1)) ? c + CNT_ONE : c;
  endfunction

  logic [1:0]                     state;
  logic [7:0]                     proto_q;
  logic [31:0]                    src_q;
  logic [15:0]                    dst_hi_q;
  key_t                           key_q;
  logic                           key_vld;

  logic [C_S_AXIS_DATA_WIDTH-1:0] tdata;
  logic                           tlast;
  logic                           beat;
  logic                           key_take;
  logic                           is_ipv4;
  logic                           hdr_ok;
  logic                           key_load;
  logic                           non_ip_inc;
  logic                           runt_inc;
  logic                           unused_keep;

  assign tdata       = bus.s_axis_tdata;
  assign tlast       = bus.s_axis_tlast;
  assign unused_keep = ^bus.s_axis_tkeep[29:0];

  // Stall beat 1 only while the previous key is still waiting; a key taken this cycle frees the slot.
  assign bus.s_axis_tready = axi_resetn && !((state == HDR1) && key_vld && !bus.m_key_ready);

  assign beat     = bus.s_axis_tvalid && bus.s_axis_tready;
  assign key_take = key_vld && bus.m_key_ready;
  assign is_ipv4  = ({byte_at(tdata, 12), byte_at(tdata, 13)} == 16'h0800) &&
                    (byte_at(tdata, 14) >> 4 == 8'h04);
  assign hdr_ok   = bus.s_axis_tkeep[31] && bus.s_axis_tkeep[30];
  assign key_load = beat && (state == HDR1) && hdr_ok;

  assign non_ip_inc = beat && (state == IDLE) && !is_ipv4;
  assign runt_inc   = beat && (((state == IDLE) && is_ipv4 && tlast) ||
                               ((state == HDR1) && !hdr_ok));

  assign bus.m_key       = key_q;
  assign bus.m_key_valid = key_vld;

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state      <= IDLE;
      proto_q    <= '0;
      src_q      <= '0;
      dst_hi_q   <= '0;
      key_q      <= '0;
      key_vld    <= 1'b0;
      pkt_cnt    <= '0;
      non_ip_cnt <= '0;
      runt_cnt   <= '0;
    end else begin
      if (beat) begin
        case (state)
          IDLE: begin
            if (is_ipv4 && !tlast) begin
              state    <= HDR1;
              proto_q  <= byte_at(tdata, 23);
              src_q    <= {byte_at(tdata, 26), byte_at(tdata, 27), byte_at(tdata, 28), byte_at(tdata, 29)};
              dst_hi_q <= {byte_at(tdata, 30), byte_at(tdata, 31)};
            end else if (!tlast) begin
              state <= DRAIN;
            end
          end
          HDR1:    state <= tlast ? IDLE : DRAIN;
          DRAIN:   if (tlast) state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      // A new key may overwrite the one being handed off in the same cycle.
      if (key_load) begin
        key_q.protocol <= proto_q;
        key_q.src_ip   <= src_q;
        key_q.dst_ip   <= {dst_hi_q, byte_at(tdata, 0), byte_at(tdata, 1)};
        key_vld        <= 1'b1;
      end else if (key_take) begin
        key_vld <= 1'b0;
      end

      pkt_cnt    <= sat_inc(pkt_cnt, key_load);
      non_ip_cnt <= sat_inc(non_ip_cnt, non_ip_inc);
      runt_cnt   <= sat_inc(runt_cnt, runt_inc);
    end
  end
endmodule

// File: tb/tb_header_tuple_extractor.sv
// Directed + randomized bench for header_tuple_extractor against a byte-level packet model.
module tb_header_tuple_extractor;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic resetn;
  logic [CW-1:0] pkt_cnt, non_ip_cnt, runt_cnt;

  header_tuple_extractor_if #(.DATA_WIDTH(256)) bus ();

  header_tuple_extractor #(.C_S_AXIS_DATA_WIDTH(256), .C_CNT_WIDTH(CW)) dut (
    .axi_aclk   (clk),
    .axi_resetn (resetn),
    .bus        (bus),
    .pkt_cnt    (pkt_cnt),
    .non_ip_cnt (non_ip_cnt),
    .runt_cnt   (runt_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0]  pb [0:127];
  logic [71:0] exp_q [$];
  logic [71:0] obs_q [$];
  int n_pkt = 0, n_non = 0, n_runt = 0;
  bit rand_rdy = 1'b0;
  logic prev_hold = 1'b0;
  logic [71:0] prev_key = '0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] satx(input int n);
    return 72'((n > CMAX) ? CMAX : n);
  endfunction

  // Key monitor: records handshakes and checks that a stalled key stays put.
  always @(negedge clk) begin
    if (resetn && prev_hold) begin
      check("key_hold_vld", 72'(bus.m_key_valid), 72'd1);
      check("key_hold_dat", bus.m_key, prev_key);
    end
    if (resetn && bus.m_key_valid && bus.m_key_ready) obs_q.push_back(bus.m_key);
    prev_hold = resetn && bus.m_key_valid && !bus.m_key_ready;
    prev_key  = bus.m_key;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) bus.m_key_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 128; i++) pb[i] = 8'($urandom);
  endtask

  task automatic make_ipv4(input logic [7:0] proto, input logic [31:0] sa, input logic [31:0] da);
    fill_rand();
    pb[12] = 8'h08; pb[13] = 8'h00; pb[14] = 8'h45; pb[23] = proto;
    {pb[26], pb[27], pb[28], pb[29]} = sa;
    {pb[30], pb[31], pb[32], pb[33]} = da;
  endtask

  task automatic set_beat(input int b, input logic [31:0] keep, input logic last);
    logic [255:0] d;
    for (int i = 0; i < 32; i++) d[255-8*i -: 8] = pb[32*b+i];
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = keep;
    bus.s_axis_tlast  = last;
    bus.s_axis_tvalid = 1'b1;
  endtask

  task automatic send_beat(input int b, input logic [31:0] keep, input logic last);
    bit done = 1'b0;
    set_beat(b, keep, last);
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (bus.s_axis_tready) begin
        tick();
        done = 1'b1;
      end
    end
    if (!done) check("beat_timeout", 72'(bus.s_axis_tready), 72'd1);
    bus.s_axis_tvalid = 1'b0;
  endtask

  // Reference: classify the whole frame from its bytes and beat count.
  task automatic model_pkt(input int nb, input logic [31:0] keep1);
    if (!({pb[12], pb[13]} == 16'h0800 && pb[14][7:4] == 4'h4)) n_non++;
    else if (nb == 1) n_runt++;
    else if (keep1[31] && keep1[30]) begin
      n_pkt++;
      exp_q.push_back({pb[23], pb[26], pb[27], pb[28], pb[29], pb[30], pb[31], pb[32], pb[33]});
    end else n_runt++;
  endtask

  task automatic send_pkt(input int nb, input logic [31:0] keep1);
    for (int b = 0; b < nb; b++) send_beat(b, (b == 1) ? keep1 : 32'hFFFF_FFFF, b == nb - 1);
    model_pkt(nb, keep1);
  endtask

  task automatic check_counters();
    @(negedge clk);
    check("pkt_cnt", 72'(pkt_cnt), satx(n_pkt));
    check("non_ip_cnt", 72'(non_ip_cnt), satx(n_non));
    check("runt_cnt", 72'(runt_cnt), satx(n_runt));
    tick();
  endtask

  task automatic check_keys();
    rand_rdy = 1'b0;
    bus.m_key_ready = 1'b1;
    repeat (4) tick();
    check("key_count", 72'(obs_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) check("key_value", obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(negedge clk);
    check("tready_in_reset", 72'(bus.s_axis_tready), 72'd0);
    tick();
    resetn = 1'b1;
    n_pkt = 0; n_non = 0; n_runt = 0;
    exp_q.delete();
    obs_q.delete();
    @(negedge clk);
    check("tready_after_reset", 72'(bus.s_axis_tready), 72'd1);
    check("rst_key_valid", 72'(bus.m_key_valid), 72'd0);
    check("rst_key", bus.m_key, 72'd0);
    check("rst_pkt_cnt", 72'(pkt_cnt), 72'd0);
    check("rst_non_ip_cnt", 72'(non_ip_cnt), 72'd0);
    check("rst_runt_cnt", 72'(runt_cnt), 72'd0);
    tick();
  endtask

  initial begin
    logic [71:0] key_a;
    logic [31:0] keep;
    int kind, nb;

    resetn = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tlast  = 1'b0;
    bus.m_key_ready   = 1'b1;
    repeat (3) tick();
    do_reset();

    // TCP packet, 3 beats, key visible for exactly one cycle
    make_ipv4(8'h06, 32'hac1c0b05, 32'h551103fa);
    send_beat(0, 32'hFFFF_FFFF, 1'b0);
    send_beat(1, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    check("tcp_key_valid", 72'(bus.m_key_valid), 72'd1);
    check("tcp_key", bus.m_key, 72'h06_ac1c0b05_551103fa);
    tick();
    @(negedge clk);
    check("tcp_key_one_cycle", 72'(bus.m_key_valid), 72'd0);
    tick();
    send_beat(2, 32'hFFFF_FFFF, 1'b1);
    model_pkt(3, 32'hFFFF_FFFF);
    check_counters();
    check_keys();

    // ARP frame followed by an IPv4 frame to show the FSM is back in IDLE
    fill_rand(); pb[12] = 8'h08; pb[13] = 8'h06;
    send_pkt(2, 32'hFFFF_FFFF);
    make_ipv4(8'h11, 32'h0a000001, 32'hc0a80102);
    send_pkt(2, 32'hFFFF_FFFF);
    check_counters();
    check_keys();

    // Runts: single-beat IPv4, and beat 1 missing byte 0 or byte 1
    make_ipv4(8'h06, $urandom, $urandom);
    send_pkt(1, 32'hFFFF_FFFF);
    make_ipv4(8'h06, $urandom, $urandom);
    send_pkt(2, 32'h4000_0000);
    make_ipv4(8'h06, $urandom, $urandom);
    send_pkt(3, 32'h8000_0000);
    check_counters();
    check_keys();

    // Back-to-back UDP with the match engine stalled
    bus.m_key_ready = 1'b0;
    make_ipv4(8'h11, 32'h01020304, 32'h05060708);
    send_pkt(2, 32'hFFFF_FFFF);
    key_a = exp_q[0];
    make_ipv4(8'h11, 32'h11223344, 32'h55667788);
    send_beat(0, 32'hFFFF_FFFF, 1'b0);
    set_beat(1, 32'hFFFF_FFFF, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hdr1_stall_tready", 72'(bus.s_axis_tready), 72'd0);
      check("key_a_stable", bus.m_key, key_a);
      tick();
    end
    bus.m_key_ready = 1'b1;
    @(negedge clk);
    check("hdr1_release_tready", 72'(bus.s_axis_tready), 72'd1);
    tick();
    bus.s_axis_tvalid = 1'b0;
    model_pkt(2, 32'hFFFF_FFFF);
    @(negedge clk);
    check("key_b_valid", 72'(bus.m_key_valid), 72'd1);
    check("key_b", bus.m_key, exp_q[1]);
    tick();
    check_counters();
    check_keys();

    // Reset while in HDR1, then a clean packet
    make_ipv4(8'h06, $urandom, $urandom);
    send_beat(0, 32'hFFFF_FFFF, 1'b0);
    do_reset();
    make_ipv4(8'h06, 32'hc0000201, 32'hc6336407);
    send_pkt(3, 32'hFFFF_FFFF);
    check_counters();
    check_keys();

    // Randomized mix with random key backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 16; n++) begin
      kind = $urandom_range(0, 3);
      make_ipv4(8'($urandom), $urandom, $urandom);
      nb   = $urandom_range(2, 4);
      keep = {2'b11, 30'($urandom)};
      case (kind)
        1: begin
          if ($urandom_range(0, 1) == 1) begin pb[12] = 8'h81; pb[13] = 8'h00; end
          else pb[14] = 8'h60;
          nb = $urandom_range(1, 4);
        end
        2: nb = 1;
        3: keep = {2'($urandom_range(0, 2)), 30'($urandom)};
        default: ;
      endcase
      send_pkt(nb, keep);
    end
    rand_rdy = 1'b0;
    bus.m_key_ready = 1'b1;
    tick();
    check_counters();
    check_keys();

    // Saturation of a narrow counter
    do_reset();
    for (int n = 0; n < 20; n++) begin
      fill_rand(); pb[12] = 8'h81; pb[13] = 8'h00;
      send_pkt($urandom_range(1, 2), 32'hFFFF_FFFF);
      if (n == 14) check_counters();
    end
    check_counters();
    @(negedge clk);
    check("non_ip_saturated", 72'(non_ip_cnt), 72'hF);
    tick();
    check_keys();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
